// File: rtl/seg_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scan logic.
// Digit indices are always 3 bits wide; designs with fewer digits leave the upper indices unused.
package seg_pkg;

    localparam int unsigned SEG_DIGITS = 8;
    localparam logic [7:0]  AN_OFF     = 8'hFF;

    typedef enum logic {
        PendIdle,
        PendFull
    } pend_e;

    // Active-low one-hot anode pattern for digit idx.
    function automatic logic [7:0] an_onehot_n(input logic [2:0] idx);
        return ~(8'h01 << idx);
    endfunction

    // Index of the most significant nonzero nibble, 0 when the value is all zero.
    function automatic logic [2:0] msd_index(input logic [31:0] data);
        logic [2:0] msd;
        msd = 3'd0;
        for (int i = 0; i < SEG_DIGITS; i++) begin
            if (data[4*i +: 4] != 4'h0) begin
                msd = 3'(i);
            end
        end
        return msd;
    endfunction

endpackage

// File: rtl/seg_prescaler.sv
// Free-running slot prescaler: tick marks the last cycle of a slot; guard flags that the
// count loaded on the next edge lies inside the leading blanking window.
module seg_prescaler #(
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned GUARD    = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick,
    output logic guard
);

    localparam int unsigned    CntW     = $clog2(TICK_DIV);
    localparam logic [CntW-1:0] CntMax  = CntW'(TICK_DIV - 1);
    localparam logic [CntW-1:0] GuardLim = CntW'(GUARD);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CntMax);
        cnt_d = tick ? '0 : cnt_q + CntW'(1);
        // Look-ahead so registered consumers line up with the new slot on the same edge.
        guard = (cnt_d < GuardLim);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode hex display with double-buffered data,
// per-digit blank/point masks and optional leading-zero suppression.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS   = 8,
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned GUARD    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic [DIGITS-1:0]     point_in,
    input  logic                  load,
    input  logic                  lz_en,
    output logic [3:0]            hex,
    output logic                  le,
    output logic                  point,
    output logic [7:0]            an,
    output logic                  pending,
    output logic                  frame_done
);

    localparam int unsigned DW      = 4 * DIGITS;
    localparam logic [2:0]  IdxLast = 3'(DIGITS - 1);

    logic tick;
    logic guard_nx;
    logic wrap;

    logic [2:0] idx_q, idx_d;
    pend_e      pend_q, pend_d;
    logic       frame_done_q;

    logic [DW-1:0]     shadow_data_q, shadow_data_d;
    logic [DIGITS-1:0] shadow_blank_q, shadow_blank_d;
    logic [DIGITS-1:0] shadow_point_q, shadow_point_d;
    logic [DW-1:0]     active_data_q, active_data_d;
    logic [DIGITS-1:0] active_blank_q, active_blank_d;
    logic [DIGITS-1:0] active_point_q, active_point_d;

    logic [3:0] hex_q, hex_d;
    logic       le_q, le_d;
    logic       point_q, point_d;
    logic [7:0] an_q, an_d;

    logic [31:0] data_pad;
    logic [7:0]  blank_pad;
    logic [7:0]  point_pad;
    logic [2:0]  msd;

    seg_prescaler #(
        .TICK_DIV (TICK_DIV),
        .GUARD    (GUARD)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .guard (guard_nx)
    );

    assign wrap = tick && (idx_q == IdxLast);

    always_comb begin
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IdxLast) ? 3'd0 : idx_q + 3'd1;
        end
    end

    // Shadow/active double buffer; a load coinciding with the wrap bypasses the shadow.
    always_comb begin
        shadow_data_d  = shadow_data_q;
        shadow_blank_d = shadow_blank_q;
        shadow_point_d = shadow_point_q;
        active_data_d  = active_data_q;
        active_blank_d = active_blank_q;
        active_point_d = active_point_q;
        pend_d         = pend_q;

        if (load) begin
            shadow_data_d  = data_in;
            shadow_blank_d = blank_in;
            shadow_point_d = point_in;
        end

        if (wrap) begin
            if (load) begin
                active_data_d  = data_in;
                active_blank_d = blank_in;
                active_point_d = point_in;
            end else if (pend_q == PendFull) begin
                active_data_d  = shadow_data_q;
                active_blank_d = shadow_blank_q;
                active_point_d = shadow_point_q;
            end
            pend_d = PendIdle;
        end else if (load) begin
            pend_d = PendFull;
        end
    end

    // Outputs are derived from next-state index and buffer so they switch with idx.
    always_comb begin
        data_pad              = '0;
        data_pad[DW-1:0]      = active_data_d;
        blank_pad             = '0;
        blank_pad[DIGITS-1:0] = active_blank_d;
        point_pad             = '0;
        point_pad[DIGITS-1:0] = active_point_d;

        msd     = msd_index(data_pad);
        hex_d   = data_pad[{idx_d, 2'b00} +: 4];
        le_d    = blank_pad[idx_d] | (lz_en & (idx_d > msd));
        point_d = point_pad[idx_d] & ~le_d;
        an_d    = guard_nx ? AN_OFF : an_onehot_n(idx_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q          <= 3'd0;
            pend_q         <= PendIdle;
            frame_done_q   <= 1'b0;
            shadow_data_q  <= '0;
            shadow_blank_q <= '0;
            shadow_point_q <= '0;
            active_data_q  <= '0;
            active_blank_q <= '0;
            active_point_q <= '0;
            hex_q          <= 4'h0;
            le_q           <= 1'b1;
            point_q        <= 1'b0;
            an_q           <= AN_OFF;
        end else begin
            idx_q          <= idx_d;
            pend_q         <= pend_d;
            frame_done_q   <= wrap;
            shadow_data_q  <= shadow_data_d;
            shadow_blank_q <= shadow_blank_d;
            shadow_point_q <= shadow_point_d;
            active_data_q  <= active_data_d;
            active_blank_q <= active_blank_d;
            active_point_q <= active_point_d;
            hex_q          <= hex_d;
            le_q           <= le_d;
            point_q        <= point_d;
            an_q           <= an_d;
        end
    end

    assign hex        = hex_q;
    assign le         = le_q;
    assign point      = point_q;
    assign an         = an_q;
    assign pending    = (pend_q == PendFull);
    assign frame_done = frame_done_q;

endmodule
